// File: rtl/mips_pkg.sv
// Shared definitions for the load/store unit: the 6-bit LS opcodes, the
// LSU FSM state encoding, byte-enable patterns and opcode class helpers.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b101000;
  localparam logic [5:0] OP_LBU = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101010;
  localparam logic [5:0] OP_LH  = 6'b111000;
  localparam logic [5:0] OP_LHU = 6'b111001;
  localparam logic [5:0] OP_LW  = 6'b111010;
  localparam logic [5:0] OP_SH  = 6'b111011;
  localparam logic [5:0] OP_SW  = 6'b111100;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } lsu_state_e;

  function automatic logic is_ls_op(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_store_op(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_half_op(input logic [5:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  function automatic logic is_word_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Combinational load-lane extractor.
//   op     : latched LS opcode
//   offset : byte offset within the word (addr[1:0])
//   rdata  : raw bus read word
//   result : selected byte/half/word, sign- or zero-extended
module lsu_ext
  import mips_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    // Halfword lane depends only on offset[1]; offset[0] is don't-care here.
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    case (op)
      OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  result = {24'h0, byte_sel};
      OP_LH:   result = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  result = {16'h0, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit: accepts a load/store from execute, drives the data-memory
// request/grant/response bus, returns extended load data and stalls the
// pipeline while busy.
//   clk, reset (async, active-low)
//   ls_*      : pipeline access in, ls_ready/ls_stall out
//   rd_*      : load result pulse and data; st_done store-complete pulse
//   addr_err, bad_addr : misalignment trap pulse and faulting address
//   mem_*     : data-memory bus
// Optional: LSU_ADDR_ERR_EN builds the misalignment trap (ERR state).
//
// state | meaning
// IDLE  | ready; latch op/addr/wdata on a valid LS opcode
// REQ   | mem_req high, bus fields held until mem_gnt
// WAIT  | load granted, waiting for mem_rvalid
// RESP  | one-cycle rd_valid or st_done pulse
// ERR   | one-cycle addr_err pulse, no bus activity
module lsu_mem_port
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ls_valid,
  input  logic [5:0]        ls_op,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic              ls_edr,
  output logic              ls_ready,
  output logic              ls_stall,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              st_done,
  output logic              addr_err,
  output logic [ADDR_W-1:0] bad_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic [5:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] ext_data;
  logic [3:0]        be;
  logic [DATA_W-1:0] wd;
  logic              accept;
  logic              trap;

`ifdef LSU_ADDR_ERR_EN
  logic [ADDR_W-1:0] bad_addr_q;
  assign trap = ls_edr
              | (is_half_op(ls_op) & ls_addr[0])
              | (is_word_op(ls_op) & (ls_addr[1:0] != 2'b00));
`else
  // Without the trap, misaligned low bits are simply ignored by lane logic.
  logic unused_edr;
  assign unused_edr = ls_edr;
  assign trap       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ls_valid && is_ls_op(ls_op)) begin
          accept = 1'b1;
`ifdef LSU_ADDR_ERR_EN
          state_d = trap ? ST_ERR : ST_REQ;
`else
          state_d = ST_REQ;
`endif
        end
      end
      ST_REQ:  if (mem_gnt) state_d = is_store_op(op_q) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem_rvalid) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
`ifdef LSU_ADDR_ERR_EN
      ST_ERR:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= ls_op;
        addr_q  <= ls_addr;
        wdata_q <= ls_wdata;
      end
      if (state_q == ST_WAIT && mem_rvalid) rd_data_q <= ext_data;
    end
  end

`ifdef LSU_ADDR_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bad_addr_q <= '0;
    else if (accept && trap) bad_addr_q <= ls_addr;
  end
  assign addr_err = (state_q == ST_ERR);
  assign bad_addr = bad_addr_q;
`else
  assign addr_err = 1'b0;
  assign bad_addr = '0;
`endif

  lsu_ext u_ext (
    .op     (op_q),
    .offset (addr_q[1:0]),
    .rdata  (mem_rdata),
    .result (ext_data)
  );

  always_comb begin
    be = BE_WORD;
    wd = '0;
    case (op_q)
      OP_SB: begin
        be = BE_BYTE << addr_q[1:0];
        wd = {4{wdata_q[7:0]}};
      end
      OP_SH: begin
        be = addr_q[1] ? BE_HALF_HI : BE_HALF_LO;
        wd = {2{wdata_q[15:0]}};
      end
      OP_SW:   wd = wdata_q;
      default: begin
        be = BE_WORD;
        wd = '0;
      end
    endcase
  end

  // Bus fields are zero outside REQ so reset and idle both present a quiet bus.
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & is_store_op(op_q);
  assign mem_be    = mem_req ? be : 4'b0000;
  assign mem_addr  = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? wd : '0;

  assign ls_ready = (state_q == ST_IDLE);
  assign ls_stall = ls_valid & ~ls_ready;
  assign rd_valid = (state_q == ST_RESP) & ~is_store_op(op_q);
  assign st_done  = (state_q == ST_RESP) & is_store_op(op_q);
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        ls_valid;
  logic [5:0]  ls_op;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_edr;
  logic        ls_ready;
  logic        ls_stall;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        st_done;
  logic        addr_err;
  logic [31:0] bad_addr;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  localparam logic [5:0] LB = 6'b101000, LBU = 6'b101001, SB = 6'b101010,
                         LH = 6'b111000, LHU = 6'b111001, LW = 6'b111010,
                         SH = 6'b111011, SW = 6'b111100;

  always #5 clk = ~clk;

  lsu_mem_port dut (
    .clk        (clk),
    .reset      (reset),
    .ls_valid   (ls_valid),
    .ls_op      (ls_op),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_edr     (ls_edr),
    .ls_ready   (ls_ready),
    .ls_stall   (ls_stall),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .st_done    (st_done),
    .addr_err   (addr_err),
    .bad_addr   (bad_addr),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b0; ls_valid = 1'b0; ls_op = '0; ls_addr = '0; ls_wdata = '0;
    ls_edr = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    tests++; if (ls_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", ls_ready); end
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", mem_req); end
    tests++; if ({rd_valid, st_done, addr_err, mem_we} !== 4'b0) begin fails++; $display("FAIL rst_pulses got %b exp 0000", {rd_valid, st_done, addr_err, mem_we}); end
    tests++; if (rd_data !== 32'h0 || bad_addr !== 32'h0) begin fails++; $display("FAIL rst_data got %h/%h exp 0/0", rd_data, bad_addr); end
    tests++; if (mem_be !== 4'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin fails++; $display("FAIL rst_bus got %h %h %h exp zeros", mem_be, mem_addr, mem_wdata); end
    ls_valid = 1'b1; #1;
    tests++; if (ls_stall !== 1'b0) begin fails++; $display("FAIL rst_stall got %b exp 0", ls_stall); end
    ls_valid = 1'b0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_lb();
    ls_valid = 1'b1; ls_op = LB; ls_addr = 32'h3; mem_gnt = 1'b1;
    tick();  // T+1
    ls_valid = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin fails++; $display("FAIL lb_req got req=%b we=%b exp 1/0", mem_req, mem_we); end
    tests++; if (mem_be !== 4'b1111 || mem_addr !== 32'h0) begin fails++; $display("FAIL lb_bus got be=%b addr=%h exp 1111/0", mem_be, mem_addr); end
    tests++; if (ls_ready !== 1'b0) begin fails++; $display("FAIL lb_busy got %b exp 0", ls_ready); end
    tick();  // T+2
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF7F01;
    tests++; if (mem_req !== 1'b0) begin fails++; $display("FAIL lb_wait_req got %b exp 0", mem_req); end
    tick();  // T+3
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tests++; if (rd_valid !== 1'b1 || rd_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_data got v=%b d=%h exp 1/ffffff80", rd_valid, rd_data); end
    tick();  // T+4
    tests++; if (rd_valid !== 1'b0 || ls_ready !== 1'b1 || rd_data !== 32'hFFFFFF80) begin fails++; $display("FAIL lb_after got v=%b r=%b d=%h exp 0/1/ffffff80", rd_valid, ls_ready, rd_data); end
  endtask

  task automatic test_load_ext();
    logic [5:0]  ops [7];
    logic [31:0] adr [7];
    logic [31:0] rdv [7];
    logic [31:0] exp [7];
    ops[0] = LHU; adr[0] = 32'h2;   rdv[0] = 32'hBEEF1234; exp[0] = 32'h0000BEEF;
    ops[1] = LBU; adr[1] = 32'h1;   rdv[1] = 32'h80FF7F01; exp[1] = 32'h0000007F;
    ops[2] = LB;  adr[2] = 32'h2;   rdv[2] = 32'h80FF7F01; exp[2] = 32'hFFFFFFFF;
    ops[3] = LBU; adr[3] = 32'h3;   rdv[3] = 32'h80FF7F01; exp[3] = 32'h00000080;
    ops[4] = LH;  adr[4] = 32'h0;   rdv[4] = 32'hBEEF1234; exp[4] = 32'h00001234;
    ops[5] = LH;  adr[5] = 32'h2;   rdv[5] = 32'hBEEF1234; exp[5] = 32'hFFFFBEEF;
    ops[6] = LW;  adr[6] = 32'h24;  rdv[6] = 32'hDEADBEEF; exp[6] = 32'hDEADBEEF;
    for (int i = 0; i < 7; i++) begin
      ls_valid = 1'b1; ls_op = ops[i]; ls_addr = adr[i]; mem_gnt = 1'b1;
      tick();
      ls_valid = 1'b0;
      tests++; if (mem_addr !== {adr[i][31:2], 2'b00}) begin fails++; $display("FAIL ext%0d_addr got %h exp %h", i, mem_addr, {adr[i][31:2], 2'b00}); end
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdv[i];
      tick();
      mem_rvalid = 1'b0;
      tests++; if (rd_valid !== 1'b1 || rd_data !== exp[i]) begin fails++; $display("FAIL ext%0d_data got v=%b d=%h exp 1/%h", i, rd_valid, rd_data, exp[i]); end
      tick();
    end
  endtask

  task automatic test_store_sh_delayed();
    ls_valid = 1'b1; ls_op = SH; ls_addr = 32'h6; ls_wdata = 32'h0000CAFE; mem_gnt = 1'b0;
    tick();  // T+1
    ls_valid = 1'b0; ls_wdata = 32'h0; ls_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1100 ||
          mem_addr !== 32'h4 || mem_wdata !== 32'hCAFECAFE || st_done !== 1'b0) begin
        fails++;
        $display("FAIL sh_hold%0d got req=%b we=%b be=%b a=%h wd=%h sd=%b exp 1/1/1100/4/cafecafe/0",
                 i, mem_req, mem_we, mem_be, mem_addr, mem_wdata, st_done);
      end
      tick();
    end
    mem_gnt = 1'b1;
    tests++; if (mem_req !== 1'b1 || mem_wdata !== 32'hCAFECAFE) begin fails++; $display("FAIL sh_gnt got req=%b wd=%h exp 1/cafecafe", mem_req, mem_wdata); end
    tick();
    mem_gnt = 1'b0;
    tests++; if (st_done !== 1'b1 || mem_req !== 1'b0 || rd_valid !== 1'b0) begin fails++; $display("FAIL sh_done got sd=%b req=%b rv=%b exp 1/0/0", st_done, mem_req, rd_valid); end
    tick();
    tests++; if (st_done !== 1'b0 || ls_ready !== 1'b1) begin fails++; $display("FAIL sh_after got sd=%b r=%b exp 0/1", st_done, ls_ready); end
  endtask

  task automatic test_store_sb_sw();
    ls_valid = 1'b1; ls_op = SB; ls_addr = 32'h12; ls_wdata = 32'h123456A5; mem_gnt = 1'b1;
    tick();  // T+1
    ls_valid = 1'b0;
    tests++; if (mem_be !== 4'b0100 || mem_wdata !== 32'hA5A5A5A5 || mem_addr !== 32'h10) begin fails++; $display("FAIL sb_bus got be=%b wd=%h a=%h exp 0100/a5a5a5a5/10", mem_be, mem_wdata, mem_addr); end
    tick();  // T+2
    mem_gnt = 1'b0;
    tests++; if (st_done !== 1'b1) begin fails++; $display("FAIL sb_done got %b exp 1", st_done); end
    tick();
    ls_valid = 1'b1; ls_op = SW; ls_addr = 32'h40; ls_wdata = 32'h89ABCDEF; mem_gnt = 1'b1;
    tick();
    ls_valid = 1'b0;
    tests++; if (mem_be !== 4'b1111 || mem_wdata !== 32'h89ABCDEF || mem_we !== 1'b1) begin fails++; $display("FAIL sw_bus got be=%b wd=%h we=%b exp 1111/89abcdef/1", mem_be, mem_wdata, mem_we); end
    tick();
    mem_gnt = 1'b0;
    tests++; if (st_done !== 1'b1) begin fails++; $display("FAIL sw_done got %b exp 1", st_done); end
    tick();
  endtask

  task automatic test_non_ls_ignored();
    ls_valid = 1'b1; ls_op = 6'b000000; ls_addr = 32'h80; mem_gnt = 1'b1;
    tick();
    tests++; if (mem_req !== 1'b0 || ls_ready !== 1'b1) begin fails++; $display("FAIL nonls got req=%b r=%b exp 0/1", mem_req, ls_ready); end
    ls_valid = 1'b0; mem_gnt = 1'b0;
    tick();
  endtask

  task automatic test_misaligned();
    ls_valid = 1'b1; ls_op = LW; ls_addr = 32'h102; ls_edr = 1'b1; mem_gnt = 1'b1;
    tick();  // T+1
    ls_valid = 1'b0; ls_edr = 1'b0;
`ifdef LSU_ADDR_ERR_EN
    tests++; if (addr_err !== 1'b1 || mem_req !== 1'b0 || bad_addr !== 32'h102) begin fails++; $display("FAIL mis_trap got ae=%b req=%b ba=%h exp 1/0/102", addr_err, mem_req, bad_addr); end
    tick();
    mem_gnt = 1'b0;
    tests++; if (addr_err !== 1'b0 || ls_ready !== 1'b1 || bad_addr !== 32'h102 || mem_req !== 1'b0) begin fails++; $display("FAIL mis_after got ae=%b r=%b ba=%h req=%b exp 0/1/102/0", addr_err, ls_ready, bad_addr, mem_req); end
`else
    tests++; if (addr_err !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin fails++; $display("FAIL mis_load got ae=%b req=%b a=%h exp 0/1/100", addr_err, mem_req, mem_addr); end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11223344;
    tick();
    mem_rvalid = 1'b0;
    tests++; if (rd_valid !== 1'b1 || rd_data !== 32'h11223344 || bad_addr !== 32'h0) begin fails++; $display("FAIL mis_data got v=%b d=%h ba=%h exp 1/11223344/0", rd_valid, rd_data, bad_addr); end
    tick();
`endif
  endtask

  task automatic test_reset_mid();
    ls_valid = 1'b1; ls_op = LW; ls_addr = 32'h8; mem_gnt = 1'b1;
    tick();  // REQ
    ls_valid = 1'b0;
    tick();  // WAIT
    mem_gnt = 1'b0;
    reset = 1'b0;
    #1;
    tests++; if (mem_req !== 1'b0 || ls_ready !== 1'b1 || rd_data !== 32'h0 || rd_valid !== 1'b0) begin fails++; $display("FAIL rmid_async got req=%b r=%b d=%h v=%b exp 0/1/0/0", mem_req, ls_ready, rd_data, rd_valid); end
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
    tick();
    reset = 1'b1;
    tick();
    tests++; if (rd_valid !== 1'b0 || rd_data !== 32'h0 || mem_req !== 1'b0 || ls_ready !== 1'b1) begin fails++; $display("FAIL rmid_late got v=%b d=%h req=%b r=%b exp 0/0/0/1", rd_valid, rd_data, mem_req, ls_ready); end
    mem_rvalid = 1'b0;
    ls_valid = 1'b1; ls_op = LW; ls_addr = 32'hC; mem_gnt = 1'b1;
    tick();
    ls_valid = 1'b0;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    tests++; if (rd_valid !== 1'b1 || rd_data !== 32'hCAFEF00D) begin fails++; $display("FAIL rmid_next got v=%b d=%h exp 1/cafef00d", rd_valid, rd_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    ls_valid = 1'b1; ls_op = LW; ls_addr = 32'h10;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h01234567;
    tick();  // T+1
    tests++; if (ls_stall !== 1'b1 || mem_addr !== 32'h10) begin fails++; $display("FAIL b2b_stall1 got s=%b a=%h exp 1/10", ls_stall, mem_addr); end
    tick();  // T+2
    tests++; if (ls_stall !== 1'b1) begin fails++; $display("FAIL b2b_stall2 got %b exp 1", ls_stall); end
    tick();  // T+3
    tests++; if (rd_valid !== 1'b1 || rd_data !== 32'h01234567 || ls_stall !== 1'b1) begin fails++; $display("FAIL b2b_first got v=%b d=%h s=%b exp 1/01234567/1", rd_valid, rd_data, ls_stall); end
    ls_addr = 32'h14; mem_rdata = 32'h89ABCDEF;
    tick();  // T+4: second access accepted at the end of this cycle
    tests++; if (ls_ready !== 1'b1 || ls_stall !== 1'b0) begin fails++; $display("FAIL b2b_ready got r=%b s=%b exp 1/0", ls_ready, ls_stall); end
    tick();  // T+5
    ls_valid = 1'b0;
    tests++; if (mem_req !== 1'b1 || mem_addr !== 32'h14) begin fails++; $display("FAIL b2b_second got req=%b a=%h exp 1/14", mem_req, mem_addr); end
    tick(); tick();  // T+7
    tests++; if (rd_valid !== 1'b1 || rd_data !== 32'h89ABCDEF) begin fails++; $display("FAIL b2b_data got v=%b d=%h exp 1/89abcdef", rd_valid, rd_data); end
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_lb();
    test_load_ext();
    test_store_sh_delayed();
    test_store_sb_sw();
    test_non_ls_ignored();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store unit that consumes the ALU's load/store opcode, the translated address and the misalignment flag, and performs the data-memory access. It sits between the execute stage and the data-memory bus. It generates byte lanes and store-data replication, runs a request/grant/response handshake, and returns sign- or zero-extended load data. It stalls the pipeline while an access is outstanding.

## Interface
Parameters:
- ADDR_W, 32, address width. Fixed; no other value is supported.
- DATA_W, 32, data width. Fixed.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- ls_valid  in  1  pipeline presents an access.
- ls_op  in  6  operation code: LB=101000, LBU=101001, SB=101010, LH=111000, LHU=111001, LW=111010, SH=111011, SW=111100.
- ls_addr  in  32  byte address, already segment-translated by the ALU.
- ls_wdata  in  32  store data (rt).
- ls_edr  in  1  misalignment flag from the ALU.
- ls_ready  out  1  unit can accept an access.
- ls_stall  out  1  equals ls_valid & ~ls_ready.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- rd_data  out  32  extended load result.
- st_done  out  1  one-cycle pulse; store has been granted.
- addr_err  out  1  one-cycle pulse; misaligned access was trapped.
- bad_addr  out  32  faulting address.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables, little-endian (bit i = byte lane i).
- mem_addr  out  32  word address; {ls_addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-replicated store data.
- mem_gnt  in  1  bus accepts the request this cycle.
- mem_rvalid  in  1  read data is valid.
- mem_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP, ERR.
- IDLE: ls_ready=1. If ls_valid and ls_op is an LS opcode, latch op, addr and wdata.
  - Go to ERR if the access is trapped as misaligned (see Configuration).
  - Otherwise go to REQ.
  - ls_valid with a non-LS opcode is ignored; the unit stays in IDLE.
- REQ: mem_req=1. mem_addr, mem_we, mem_be and mem_wdata stay stable until mem_gnt is sampled high.
  - Load: on gnt, go to WAIT.
  - Store: on gnt, go to RESP.
- WAIT: on mem_rvalid, register the extended data and go to RESP.
- RESP: pulse rd_valid (load) or st_done (store), then go to IDLE.
- ERR: pulse addr_err, then go to IDLE. No bus activity occurs.
- Byte lane select o = addr[1:0].
  - SB: be = 4'b0001<<o; wdata = {4{wdata[7:0]}}.
  - SH: be = o[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - SW: be = 1111.
  - Loads: be = 1111; mem_we=0.
- Load extraction:
  - LB and LBU select byte o; LB sign-extends bit 7, LBU zero-extends.
  - LH and LHU select half o[1]; LH sign-extends bit 15, LHU zero-extends.
  - LW takes the full word.
- rd_data and bad_addr hold their values until the next update.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.

## Timing
- Reset values:
  - State is IDLE, so ls_ready=1 and ls_stall follows ls_valid & ~ls_ready.
  - All other outputs, including mem_req, rd_data and bad_addr, are 0.
- Accept edge T; mem_req is high from T+1.
- Minimum load: gnt at T+1, rvalid at T+2, rd_valid at T+3.
- Minimum store: gnt at T+1, st_done at T+2.
- Trapped access: addr_err at T+1.
- ls_ready is low from T+1 until the cycle after the RESP or ERR pulse.
  - Back-to-back minimum-latency loads issue every 4 cycles.
- An unbounded gnt or rvalid wait holds the state; the unit has no timeout.
- Reset asserted mid-operation:
  - Immediate return to IDLE; mem_req deasserts asynchronously.
  - The outstanding response is discarded.
  - A late rvalid arriving in IDLE is ignored.

## Configuration
- LSU_ADDR_ERR_EN defined:
  - An access traps when ls_edr=1, or when an LH/LHU/SH has addr[0]=1, or when an LW/SW has addr[1:0]≠0.
  - A trap takes the ERR path and latches bad_addr = ls_addr.
- LSU_ADDR_ERR_EN undefined:
  - ls_edr is ignored.
  - For halfword accesses addr[0] is treated as 0; for word accesses addr[1:0] is treated as 0.
  - addr_err and bad_addr are tied to 0, and the ERR state is not built.

## Structure
- Shared package mips_pkg holds:
  - the 6-bit LS opcode constants above;
  - the FSM state enum;
  - the byte-enable constants.
- Sub-module lsu_ext is the combinational load-lane extractor and extender: inputs op, offset and rdata; output is the 32-bit result.

## Test plan
- LB at addr 0x00000003, mem_rdata=0x80FF7F01 -> be=1111, mem_addr=0x00000000, rd_data=0xFFFFFF80 at T+3.
- LHU at addr 0x00000002, mem_rdata=0xBEEF1234 -> rd_data=0x0000BEEF.
- SH at addr 0x00000006, ls_wdata=0x0000CAFE, gnt delayed 3 cycles -> be=1100, mem_wdata=0xCAFECAFE, request held stable, st_done one cycle after gnt.
- LW at addr 0x00000102 with ls_edr=1:
  - with LSU_ADDR_ERR_EN: no mem_req, addr_err at T+1, bad_addr=0x00000102;
  - without LSU_ADDR_ERR_EN: mem_addr=0x00000100, normal load.
- reset pulled low in WAIT, then rvalid arrives -> outputs at their reset values, rd_valid stays 0, next access completes normally.
- ls_valid held high across two loads -> ls_stall high while busy, second access accepted the cycle after the first rd_valid.
